// File: rtl/parity4_rx.sv
// parity4_rx: serial receiver and parity checker for 4-bit nibbles.
// Frame on the line, one bit per EN strobe: start(0), D, C, B, A, P, stop(1).
// The nibble is recovered MSB first, and D^C^B^A is recomputed (inverted when ODD=1).
// Parity and framing errors are flagged.
// Optional feature: define PARITY4_RX_ERRCNT_EN to build the 8-bit saturating
// error counter on ERRCNT. Without it, ERRCNT is tied to 8'h00.
//
// Output semantics: VALID is a one-cycle pulse, with no back-pressure, raised in
// the cycle after the edge that samples the stop bit. Q, PERR and FERR are
// updated on that same edge and hold until the next frame completes. VALID
// fires for errored frames too; PERR/FERR qualify it.
// The internal signal `state` (type state_t) is the FSM observation point.

module parity4_rx #(
   parameter int ODD = 0
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       EN,
   input  logic       SIN,
   output logic [3:0] Q,
   output logic       VALID,
   output logic       PERR,
   output logic       FERR,
   output logic [7:0] ERRCNT
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DATA    = 3'd1,
      PAR     = 3'd2,
      STOP    = 3'd3,
      WAIT_HI = 3'd4
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] shreg;
   logic [1:0] idx;
   logic       par;
   logic       exp_par;

   // Expected parity bit for the nibble currently held in the shift register
   assign exp_par = (^shreg) ^ (ODD != 0);

   // State register; reset returns to IDLE and discards any frame in flight
   always_ff @(posedge CLK) begin
      if (!RSTN) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; only EN strobes advance the frame
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (EN && !SIN)        state_nx = DATA;
         DATA:    if (EN && idx == 2'd3) state_nx = PAR;
         PAR:     if (EN)                state_nx = STOP;
         // A low stop bit parks in WAIT_HI so a stuck-low line never looks like a start bit
         STOP:    if (EN)                state_nx = SIN ? IDLE : WAIT_HI;
         WAIT_HI: if (EN && SIN)         state_nx = IDLE;
         default:                        state_nx = IDLE;
      endcase
   end

   // Datapath: shift in data, capture parity, publish results when the frame completes
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         shreg <= 4'h0;
         idx   <= 2'd0;
         par   <= 1'b0;
         Q     <= 4'h0;
         VALID <= 1'b0;
         PERR  <= 1'b0;
         FERR  <= 1'b0;
      end else begin
         VALID <= 1'b0;
         if (EN) begin
            case (state)
               IDLE: if (!SIN) idx <= 2'd0;
               DATA: begin
                  shreg <= {shreg[2:0], SIN};
                  idx   <= idx + 2'd1;
               end
               PAR:  par <= SIN;
               STOP: begin
                  Q     <= shreg;
                  PERR  <= (par != exp_par);
                  FERR  <= ~SIN;
                  VALID <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PARITY4_RX_ERRCNT_EN
   logic [7:0] errcnt;
   logic       frame_done;
   logic       frame_err;

   assign frame_done = (state == STOP) && EN;
   assign frame_err  = (par != exp_par) || !SIN;

   // Count errored frames once each, saturating at 8'hFF
   always_ff @(posedge CLK) begin
      if (!RSTN)
         errcnt <= 8'h00;
      else if (frame_done && frame_err && errcnt != 8'hFF)
         errcnt <= errcnt + 8'd1;
   end

   assign ERRCNT = errcnt;
`else
   assign ERRCNT = 8'h00;
`endif

endmodule

// File: tb/tb_parity4_rx.sv
// tb_parity4_rx: directed bench for parity4_rx.
// An even-parity instance and an odd-parity instance share the same input stimulus.
// Expected ERRCNT values depend on whether PARITY4_RX_ERRCNT_EN is defined.

module tb_parity4_rx;

   // Clock and reset
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic en = 1'b0;
   logic sin = 1'b1;

   always #5 clk = ~clk;

   logic [3:0] q_e, q_o;
   logic       valid_e, valid_o;
   logic       perr_e, perr_o;
   logic       ferr_e, ferr_o;
   logic [7:0] errcnt_e, errcnt_o;

   parity4_rx #(.ODD(0)) dut_even (
      .CLK(clk), .RSTN(rstn), .EN(en), .SIN(sin),
      .Q(q_e), .VALID(valid_e), .PERR(perr_e), .FERR(ferr_e), .ERRCNT(errcnt_e)
   );

   parity4_rx #(.ODD(1)) dut_odd (
      .CLK(clk), .RSTN(rstn), .EN(en), .SIN(sin),
      .Q(q_o), .VALID(valid_o), .PERR(perr_o), .FERR(ferr_o), .ERRCNT(errcnt_o)
   );

   int n_cmp = 0;
   int n_err = 0;
   int vcount = 0;
   int exp_errs = 0;

   // Scoreboard check
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected ERRCNT given the bench's count of errored frames
   function automatic logic [7:0] exp_cnt(input int n);
`ifdef PARITY4_RX_ERRCNT_EN
      return (n > 255) ? 8'hFF : 8'(n);
`else
      return (n > 255) ? 8'h00 : 8'h00;
`endif
   endfunction

   // Driver: one clock with the given EN/SIN; sample 1 ns after the edge
   task automatic step(input logic e, input logic s);
      en  = e;
      sin = s;
      @(posedge clk);
      #1;
      if (valid_e === 1'b1) vcount++;
   endtask

   // Driver: a 7-bit frame, MSB first, EN held at 1
   task automatic send_frame(input logic [6:0] f);
      for (int i = 6; i >= 0; i--) step(1'b1, f[i]);
   endtask

   // Driver: a frame with three EN=0 cycles after every bit
   task automatic send_frame_gaps(input logic [6:0] f);
      for (int i = 6; i >= 0; i--) begin
         step(1'b1, f[i]);
         for (int g = 0; g < 3; g++) step(1'b0, ~f[i]);
      end
   endtask

   initial begin
      // Reset
      rstn = 1'b0;
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      chk("rst_q", {4'h0, q_e}, 8'h00);
      chk("rst_valid", {7'h0, valid_e}, 8'h00);
      chk("rst_perr", {7'h0, perr_e}, 8'h00);
      chk("rst_ferr", {7'h0, ferr_e}, 8'h00);
      chk("rst_errcnt", errcnt_e, 8'h00);
      rstn = 1'b1;
      step(1'b0, 1'b1);

      // Good frame 1011, even parity P=1
      vcount = 0;
      for (int i = 0; i < 6; i++) step(1'b1, i == 0 ? 1'b0 : (i == 2 ? 1'b0 : 1'b1));
      chk("t1_no_early_valid", 8'(vcount), 8'd0);
      step(1'b1, 1'b1);
      chk("t1_valid", {7'h0, valid_e}, 8'h01);
      chk("t1_q", {4'h0, q_e}, 8'h0B);
      chk("t1_perr", {7'h0, perr_e}, 8'h00);
      chk("t1_ferr", {7'h0, ferr_e}, 8'h00);
      step(1'b1, 1'b1);
      chk("t1_valid_drop", {7'h0, valid_e}, 8'h00);
      chk("t1_pulses", 8'(vcount), 8'd1);

      // Same nibble with P=0: parity error
      send_frame(7'b0101101);
      exp_errs++;
      chk("t2_q", {4'h0, q_e}, 8'h0B);
      chk("t2_perr", {7'h0, perr_e}, 8'h01);
      chk("t2_ferr", {7'h0, ferr_e}, 8'h00);
      chk("t2_errcnt", errcnt_e, exp_cnt(exp_errs));

      // Stop bit 0, line held low, then high, then a good 0110 frame
      vcount = 0;
      send_frame(7'b0101110);
      exp_errs++;
      chk("t3_ferr", {7'h0, ferr_e}, 8'h01);
      chk("t3_perr", {7'h0, perr_e}, 8'h00);
      chk("t3_errcnt", errcnt_e, exp_cnt(exp_errs));
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("t3_no_spurious", 8'(vcount), 8'd1);
      send_frame(7'b0011001);
      chk("t3_q2", {4'h0, q_e}, 8'h06);
      chk("t3_ferr2", {7'h0, ferr_e}, 8'h00);
      chk("t3_perr2", {7'h0, perr_e}, 8'h00);
      chk("t3_pulses", 8'(vcount), 8'd2);

      // Gapped frame 1100, VALID one cycle only, outputs hold across the trailing gap
      vcount = 0;
      send_frame_gaps(7'b0110001);
      chk("t4_q", {4'h0, q_e}, 8'h0C);
      chk("t4_perr", {7'h0, perr_e}, 8'h00);
      chk("t4_valid_low", {7'h0, valid_e}, 8'h00);
      chk("t4_pulses", 8'(vcount), 8'd1);

      // Reset mid-frame, then a good 0001 frame
      vcount = 0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      rstn = 1'b0;
      step(1'b1, 1'b0);
      rstn = 1'b1;
      exp_errs = 0;
      chk("t5_rst_q", {4'h0, q_e}, 8'h00);
      chk("t5_rst_errcnt", errcnt_e, 8'h00);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("t5_no_abort_valid", 8'(vcount), 8'd0);
      send_frame(7'b0000111);
      chk("t5_q", {4'h0, q_e}, 8'h01);
      chk("t5_perr", {7'h0, perr_e}, 8'h00);
      chk("t5_pulses", 8'(vcount), 8'd1);

      // 260 back-to-back bad-parity frames: ERRCNT saturates
      vcount = 0;
      for (int k = 0; k < 260; k++) send_frame(7'b0000011);
      exp_errs += 260;
      chk("t6_pulses", 8'(vcount - 4), 8'd0);
      chk("t6_perr", {7'h0, perr_e}, 8'h01);
      chk("t6_errcnt_sat", errcnt_e, exp_cnt(exp_errs));

      // Odd parity: nibble 1011 with P=0 is correct for ODD=1
      send_frame(7'b0101101);
      chk("t7_odd_q", {4'h0, q_o}, 8'h0B);
      chk("t7_odd_perr", {7'h0, perr_o}, 8'h00);
      chk("t7_even_perr", {7'h0, perr_e}, 8'h01);
      chk("t7_errcnt_hold", errcnt_e, exp_cnt(exp_errs + 1));

      // Final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/parity4_rx.md
# parity4_rx

Serial receiver and parity checker for 4-bit nibbles framed with a start bit, the four data bits in D, C, B, A order, a parity bit and a stop bit. It is the far end of the team's 4-input XOR parity generator: it recovers the nibble, recomputes D^C^B^A, and flags parity and framing errors. It sits between the serial line and downstream logic that consumes checked nibbles.

## Interface
Parameters:
- ODD — default 0. 0 selects even parity, so the expected parity bit is D^C^B^A. 1 selects odd parity, so the expected bit is ~(D^C^B^A).

Ports:
- CLK — input, 1 — single clock; all state updates on the rising edge.
- RSTN — input, 1 — reset, synchronous and active-low.
- EN — input, 1 — bit strobe; SIN is sampled only on edges where EN=1.
- SIN — input, 1 — serial line; idles high.
- Q — output, 4 — last received nibble, Q[3]=D, Q[2]=C, Q[1]=B, Q[0]=A.
- VALID — output, 1 — one-cycle pulse when a frame completes.
- PERR — output, 1 — parity mismatch on the last frame.
- FERR — output, 1 — stop bit was 0 on the last frame.
- ERRCNT — output, 8 — saturating count of errored frames (see Configuration).

## Operation
- Frame format, one bit per EN sample: start (0), D, C, B, A, P, stop (1).
- States:
  - IDLE: on an EN sample with SIN=0, go to DATA with the bit index cleared. An EN sample with SIN=1 stays in IDLE.
  - DATA: shift four EN samples into the shift register, MSB first (D first). After the 4th sample, go to PAR.
  - PAR: capture P on the next EN sample, then go to STOP.
  - STOP: on the next EN sample, complete the frame. If SIN=1, go to IDLE. If SIN=0, go to WAIT_HI.
  - WAIT_HI: stay until an EN sample with SIN=1, then go to IDLE. A low line after a framing error is never taken as a new start bit.
- Frame completion, all on the same edge:
  - Q <= shift register.
  - PERR <= (P != expected parity).
  - FERR <= ~stop.
  - VALID <= 1.
- VALID asserts for every completed frame, including errored ones. PERR and FERR qualify it.
- Q, PERR and FERR hold their values until the next frame completes.
- Edges with EN=0 never change state, the shift register or the bit index. Gaps of any length inside a frame are legal.
- ERRCNT increments by 1 on a completed frame with PERR|FERR. It increments once per frame even if both errors are present. It saturates at 8'hFF.

## Timing
- Reset (RSTN=0 at a rising edge):
  - State goes to IDLE; shift register and bit index are cleared.
  - Outputs: Q=4'h0, VALID=0, PERR=0, FERR=0, ERRCNT=8'h00.
- Reset takes priority over every other event. A frame in progress when reset is asserted is discarded and produces no VALID.
- Latency: VALID, Q and the flags are visible in the cycle after the edge that samples the stop bit. With EN held at 1, that is 7 cycles after the edge that samples the start bit.
- VALID is exactly one CLK cycle wide, regardless of EN.
- Back-to-back frames: a start bit may be sampled on the EN strobe that immediately follows the stop bit, so the minimum frame period is 7 EN strobes.

## Configuration
- Macro PARITY4_RX_ERRCNT_EN.
- Defined: the 8-bit saturating error counter is built and drives ERRCNT.
- Not defined: no counter logic is built; ERRCNT is tied to 8'h00 so the port list is unchanged.

## Test plan
- Even parity, EN=1, SIN stream 0,1,0,1,1,1,1 → one VALID pulse; Q=4'b1011, PERR=0, FERR=0.
- Same frame with P=0 → Q=4'b1011, PERR=1, FERR=0. With the macro defined, ERRCNT goes 0→1.
- Stop bit 0, then SIN held low for 5 EN strobes, then high, then a good frame for 4'b0110 → first VALID with FERR=1. No spurious frame while the line is low. Second VALID with Q=4'b0110, FERR=0.
- EN=0 for 3 cycles between every bit of the frame 0,1,1,0,0,0,1 → Q=4'b1100, PERR=0, VALID high for one cycle only.
- RSTN=0 for one edge after the 2nd data bit, then a full good frame for 4'b0001 → no VALID for the aborted frame; the next frame gives Q=4'b0001.
- Macro defined, 260 consecutive bad-parity frames → ERRCNT stops at 8'hFF. ODD=1 with the frame 0,1,0,1,1,0,1 → PERR=0.
